// File: rtl/mac_seq_ctrl.sv
// MAC sequencer: streams len operand pairs through an 8x8 multiplier and accumulates the products.
// Optional saturating accumulate with sticky ovf flag when MAC_SAT_EN is defined.

module multiplier (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [21:0] o_p
);
  logic [15:0] w_prod;

  assign w_prod = 16'(i_a) * 16'(i_b);
  assign o_p    = {6'd0, w_prod};
endmodule

module mac_seq_ctrl #(
  parameter int LEN_W = 7,
  parameter int ACC_W = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_count;
  logic [ACC_W-1:0]   r_pq;
  logic               r_pvld;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_prod;
  logic               w_accept;
  logic               w_cmd;

  multiplier u_mult (
    .i_a (a),
    .i_b (b),
    .o_p (w_prod)
  );

  assign w_accept = in_valid && (r_state == S_RUN);
  assign w_cmd    = start && (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = (len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        in_ready = 1'b1;
        if (in_valid && (r_count == LEN_W'(1))) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Product stage: one registered product per accepted beat; p_vld drops on any idle cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pq    <= '0;
      r_pvld  <= 1'b0;
      r_count <= '0;
    end else begin
      r_pvld <= w_accept;
      if (w_accept) begin
        r_pq    <= w_prod;
        r_count <= r_count - LEN_W'(1);
      end else if (w_cmd && (len != '0)) begin
        r_count <= len;
      end
    end
  end

`ifdef MAC_SAT_EN
  logic               r_ovf;
  logic [ACC_W:0]     w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, r_pq};

  // Once saturated, the accumulator is pinned at all-ones until the next command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_cmd) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (r_pvld) begin
      if (w_sum[ACC_W] || r_ovf) begin
        r_acc <= '1;
        r_ovf <= 1'b1;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
      end
    end
  end

  assign ovf = r_ovf;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_cmd) begin
      r_acc <= '0;
    end else if (r_pvld) begin
      r_acc <= r_acc + r_pq;
    end
  end

  assign ovf = 1'b0;
`endif

  assign acc_out = r_acc;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: commands push expected results, a monitor checks them on done.
// Reference model is a plain sum of products with optional clamp (MAC_SAT_EN).

module tb_mac_seq_ctrl;
  localparam int LEN_W = 7;
  localparam int ACC_W = 22;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;

  int   nCompared   = 0;
  int   nMismatched = 0;
  exp_t expQ[$];
  int   opA[$];
  int   opB[$];
  bit   prevDone = 1'b0;

  mac_seq_ctrl #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .acc_out  (acc_out),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  task automatic failNote(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference: true sum of all products, then clamp or wrap.
  function automatic exp_t model(input int n);
    exp_t   e;
    longint sum = 0;
    for (int i = 0; i < n; i++) sum += longint'(opA[i]) * longint'(opB[i]);
`ifdef MAC_SAT_EN
    if (sum > longint'((1 << ACC_W) - 1)) begin
      e.acc = '1;
      e.ovf = 1'b1;
    end else begin
      e.acc = ACC_W'(sum);
      e.ovf = 1'b0;
    end
`else
    e.acc = ACC_W'(sum % (longint'(1) << ACC_W));
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (done) begin
      checkOutput("done_single_cycle", prevDone, 0);
      if (expQ.size() == 0) begin
        failNote("unexpected_done");
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("acc_out", acc_out, e.acc);
        checkOutput("ovf", ovf, e.ovf);
      end
    end
    prevDone = done;
  end

  task automatic sendBeat(input int va, input int vb);
    int w = 0;
    a = 8'(va);
    b = 8'(vb);
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) failNote("beat_accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDone(output int cyc, output bit sawReady);
    cyc = 0;
    sawReady = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      sawReady |= in_ready;
      checkOutput("busy_while_active", busy, 1);
    end while (!done && cyc < 400);
    if (!done) failNote("wait_done");
  endtask

  task automatic issueStart(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    len   = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic randOps(input int n);
    opA.delete();
    opB.delete();
    for (int i = 0; i < n; i++) begin
      opA.push_back($urandom_range(255, 0));
      opB.push_back($urandom_range(255, 0));
    end
  endtask

  // Runs one full command from opA/opB with random stall gaps in [gMin,gMax].
  task automatic applyStimulus(input int n, input int gMin, input int gMax);
    int cyc;
    bit sawReady;
    expQ.push_back(model(n));
    issueStart(n);
    for (int i = 0; i < n; i++) begin
      sendBeat(opA[i], opB[i]);
      if (i < n - 1) begin
        int g;
        g = $urandom_range(gMax, gMin);
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          checkOutput("in_ready_stall", in_ready, 1);
          checkOutput("busy_stall", busy, 1);
          @(posedge clk); #1;
        end
      end
    end
    waitDone(cyc, sawReady);
    checkOutput("done_latency", cyc, (n == 0) ? 1 : 2);
    checkOutput("in_ready_after_last", sawReady, 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    bit sawReady;
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_acc_out", acc_out, 0);
    checkOutput("rst_ovf", ovf, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    opA = '{2, 4, 255}; opB = '{3, 5, 255};
    applyStimulus(3, 0, 0);
    checkOutput("vec3_value", acc_out, 65051);
    applyStimulus(3, 4, 4);
    checkOutput("vec3_stall_value", acc_out, 65051);

    opA.delete(); opB.delete();
    applyStimulus(0, 0, 0);
    checkOutput("len0_acc", acc_out, 0);

    opA.delete(); opB.delete();
    for (int i = 0; i < 127; i++) begin
      opA.push_back(255);
      opB.push_back(255);
    end
    applyStimulus(127, 0, 0);

    // start during RUN must be ignored
    randOps(2);
    expQ.push_back(model(2));
    issueStart(2);
    sendBeat(opA[0], opB[0]);
    start = 1'b1;
    len   = LEN_W'(5);
    @(posedge clk); #1;
    start = 1'b0;
    sendBeat(opA[1], opB[1]);
    waitDone(cyc, sawReady);
    checkOutput("ignored_start_latency", cyc, 2);
    randOps(1);
    applyStimulus(1, 0, 0);

    // reset mid-command discards the partial sum, no done
    opA = '{200, 1, 1}; opB = '{100, 1, 1};
    issueStart(3);
    sendBeat(opA[0], opB[0]);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_acc_out", acc_out, 0);
    checkOutput("midrst_done", done, 0);
    repeat (5) @(posedge clk);
    #1;
    opA = '{7}; opB = '{9};
    applyStimulus(1, 0, 0);
    checkOutput("after_rst_value", acc_out, 63);

    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(10, 1);
      randOps(n);
      applyStimulus(n, 0, 2);
    end

    repeat (4) @(posedge clk);
    checkOutput("queue_empty", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer for the MAC datapath. Accepts a START command with a vector length, streams LEN operand pairs through a valid/ready input, and multiplies each pair using an internal instance of the team's 8x8 unsigned `multiplier` (22-bit product). Products are registered and accumulated into a 22-bit accumulator. DONE pulses when the final sum is stable on acc_out.

Parameters:
LEN_W, 7, width of len port; max vector length 2^LEN_W-1 (127)
ACC_W, 22, accumulator/result width; must equal multiplier product width

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  command strobe; sampled only in IDLE
len  input  LEN_W  number of operand pairs, sampled with start
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operand pair
a  input  8  unsigned operand A
b  input  8  unsigned operand B
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse, result valid
acc_out  output  ACC_W  accumulator value; holds last result until next accepted start
ovf  output  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk; synchronous active-low reset rst_n, sampled on the rising edge.
- Reset values: state=IDLE, in_ready=0, busy=0, done=0, acc_out=0, ovf=0, product register p_q=0, p_vld=0, count=0.
- Reset mid-operation: on the next edge the block returns to IDLE with all reset values; any partial sum is discarded and no done pulse is issued.
- FSM states: IDLE, RUN, DRAIN, DONE. State register only; in_ready, busy and done decode from it.
- IDLE:
  - in_ready=0.
  - start=1 with len!=0: acc<=0, ovf<=0, count<=len, go to RUN.
  - start=1 with len==0: acc<=0, ovf<=0, go directly to DONE.
- RUN:
  - in_ready=1. Beat accepted when in_valid && in_ready.
  - On each accepted beat: p_q<=multiplier(a,b), p_vld<=1, count<=count-1.
  - An accepted beat with count==1 moves the FSM to DRAIN.
  - No beat (in_valid=0): p_vld<=0 and state holds; stalls of any length are legal.
- DRAIN: in_ready=0; the final product is accumulated; go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, in_ready=0; go to IDLE.
- Accumulate path: every cycle with p_vld=1, acc<=acc+p_q at ACC_W bits (overflow handling per Optional Feature). p_vld clears in DRAIN.
- Latency: if the last beat is accepted at edge E0, the accumulate occurs at E0+1 and done is high during the cycle after E0+1. Throughput is one pair per cycle.
- start while busy is ignored and has no effect on len.
- acc_out = acc register; it is not cleared by done, only by an accepted start or reset.
- The multiplier instance is unsigned 8x8; the upper 6 product bits are always 0.

Optional Feature:
Macro MAC_SAT_EN.
- Defined: accumulate is computed at ACC_W+1 bits. On carry out, acc saturates to all-ones (22'h3FFFFF) and stays saturated for the rest of the command, and ovf<=1. ovf is sticky until the next accepted start or reset.
- Undefined: accumulate wraps modulo 2^ACC_W and ovf is tied to 0.

Test Plan:
- Reset, then start with len=3 and pairs (2,3),(4,5),(255,255) back-to-back -> done exactly 2 cycles after the 3rd accept edge; acc_out=65051 (0x00FE1B); busy high from start+1 through the done cycle.
- Same command with in_valid deasserted 4 cycles between beats -> in_ready held high throughout; identical result 0x00FE1B; exactly one done pulse.
- start with len=0 -> done on the cycle after the start edge, acc_out=0, in_ready never asserted.
- len=127, all pairs (255,255) -> with MAC_SAT_EN: acc_out=0x3FFFFF, ovf=1; without: acc_out=4063871 (8258175 mod 2^22), ovf=0.
- start pulsed again during RUN with len=5 during a len=2 command -> ignored; result equals the len=2 sum; the next idle start is then accepted.
- rst_n=0 for one cycle after 1 of 3 beats -> next cycle IDLE, acc_out=0, no done; a fresh len=1 command (7,9) -> acc_out=63.
